uart_tx_param: RTL and testbench

Parametrised UART transmit engine: accepts a DATA_WIDTH-bit word over a valid/ready handshake and drives one serial frame on TxOut. Each frame is a start bit, data LSB first, an optional even/odd parity bit, and one or two stop bits. One frame bit is sent per CLK cycle; CLK is the bit clock generated by the system clock divider. The block replaces the split FSM/serializer/parity/mux TX path with a single registered-output engine and adds runtime parity type, stop-bit count and an optional holding register.

---
 rtl/uart_tx_param_if.sv | 21 ++
 rtl/uart_tx_param.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Word-side handshake of the UART transmit engine: data word, valid/ready and per-frame mode bits.
interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] pdata;
    logic                  data_valid;
    logic                  data_ready;
    logic                  parity_en;
    logic                  parity_type;
    logic                  stop_two;

    modport master (
        output pdata, data_valid, parity_en, parity_type, stop_two,
        input  data_ready
    );

    modport slave (
        input  pdata, data_valid, parity_en, parity_type, stop_two,
        output data_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// UART transmit engine: start bit, LSB-first data, optional parity, one or two stop bits, one bit per clock.
// Define TX_HOLD_REG_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_param #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    uart_tx_param_if.slave tx_if,
    output logic           o_tx_out,
    output logic           o_busy,
    output logic           o_frame_done
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CNT_W-1:0]      w_bit_cnt_next;
    logic                  r_stop_second;
    logic                  w_stop_second_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_stop_two;

    logic                  w_xfer;
    logic                  w_last_stop;
    logic                  w_slot_free;
    logic                  w_launch;
    logic                  w_tx_next;
    logic                  w_frame_done_next;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_load_par_en;
    logic                  w_load_par_type;
    logic                  w_load_stop_two;

    assign w_xfer      = tx_if.data_valid && tx_if.data_ready;
    assign w_last_stop = (r_state == ST_STOP) && (!r_stop_two || r_stop_second);
    // A new frame may start from IDLE or straight after the final stop bit, leaving no idle gap.
    assign w_slot_free = (r_state == ST_IDLE) || w_last_stop;

`ifdef TX_HOLD_REG_EN
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_par_en;
    logic                  r_hold_par_type;
    logic                  r_hold_stop_two;
    logic                  w_from_hold;
    logic                  w_fill_hold;

    assign tx_if.data_ready = i_rst_n && !r_hold_full;
    assign w_from_hold      = r_hold_full && w_slot_free;
    assign w_fill_hold      = w_xfer && !w_slot_free;
    assign w_launch         = w_from_hold || (w_xfer && w_slot_free);
    assign w_load_data      = w_from_hold ? r_hold_data     : tx_if.pdata;
    assign w_load_par_en    = w_from_hold ? r_hold_par_en   : tx_if.parity_en;
    assign w_load_par_type  = w_from_hold ? r_hold_par_type : tx_if.parity_type;
    assign w_load_stop_two  = w_from_hold ? r_hold_stop_two : tx_if.stop_two;

    // Refill and drain never coincide: a transfer needs an empty hold entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_full <= 1'b0;
        end else if (w_fill_hold) begin
            r_hold_full <= 1'b1;
        end else if (w_from_hold) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fill_hold) begin
            r_hold_data     <= tx_if.pdata;
            r_hold_par_en   <= tx_if.parity_en;
            r_hold_par_type <= tx_if.parity_type;
            r_hold_stop_two <= tx_if.stop_two;
        end
    end
`else
    assign tx_if.data_ready = i_rst_n && w_slot_free;
    assign w_launch         = w_xfer;
    assign w_load_data      = tx_if.pdata;
    assign w_load_par_en    = tx_if.parity_en;
    assign w_load_par_type  = tx_if.parity_type;
    assign w_load_stop_two  = tx_if.stop_two;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next       = r_state;
        w_bit_cnt_next     = r_bit_cnt;
        w_stop_second_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next   = ST_DATA;
                w_bit_cnt_next = '0;
            end
            ST_DATA: begin
                if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (!w_last_stop) begin
                    w_stop_second_next = 1'b1;
                end else begin
                    w_state_next = w_launch ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Line value is looked up for the state being entered so the output can be registered.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_shift[w_bit_cnt_next];
            ST_PARITY: w_tx_next = (^r_shift) ^ r_par_type;
            default:   w_tx_next = 1'b1;
        endcase

        w_frame_done_next = (w_state_next == ST_STOP) && (!r_stop_two || w_stop_second_next);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_stop_second <= 1'b0;
            o_tx_out      <= 1'b1;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_stop_second <= w_stop_second_next;
            o_tx_out      <= w_tx_next;
            o_busy        <= (w_state_next != ST_IDLE);
            o_frame_done  <= w_frame_done_next;
        end
    end

    // NOTE: the frame datapath has no reset; it is always loaded at launch before any state reads it.
    always_ff @(posedge i_clk) begin
        if (w_launch) begin
            r_shift    <= w_load_data;
            r_par_en   <= w_load_par_en;
            r_par_type <= w_load_par_type;
            r_stop_two <= w_load_stop_two;
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param with hand-computed frame bit patterns.
module tb_uart_tx_param;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    logic tx_out;
    logic busy;
    logic frame_done;
    int   n_checks;
    int   n_errors;

    uart_tx_param_if #(.DATA_WIDTH(DW)) tx_if ();

    uart_tx_param #(.DATA_WIDTH(DW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .tx_if        (tx_if.slave),
        .o_tx_out     (tx_out),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one step after the transfer edge; bit j of exp_bits is the line value in frame cycle j.
    task automatic check_frame(input string tag, input logic [15:0] exp_bits, input int len);
        for (int j = 0; j < len; j++) begin
            if (j > 0) tick();
            check($sformatf("%s tx[%0d]", tag, j), 32'(tx_out), 32'(exp_bits[j]));
            check($sformatf("%s busy[%0d]", tag, j), 32'(busy), 32'd1);
            check($sformatf("%s done[%0d]", tag, j), 32'(frame_done), (j == len - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_idle(input string tag);
        tick();
        check({tag, " idle tx"}, 32'(tx_out), 32'd1);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(frame_done), 32'd0);
        check({tag, " idle ready"}, 32'(tx_if.data_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset held for two cycles with a word already offered.
        rst_n                = 1'b0;
        tx_if.data_valid     = 1'b1;
        tx_if.pdata          = 8'hA5;
        tx_if.parity_en      = 1'b1;
        tx_if.parity_type    = 1'b0;
        tx_if.stop_two       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset tx", 32'(tx_out), 32'd1);
            check("reset busy", 32'(busy), 32'd0);
            check("reset done", 32'(frame_done), 32'd0);
            check("reset ready", 32'(tx_if.data_ready), 32'd0);
        end

        // First edge with reset released takes A5: 0,1,0,1,0,0,1,0,1 | even parity 0 | stop 1.
        rst_n = 1'b1;
        tick();
        tx_if.data_valid = 1'b0;
        check_frame("a5", 16'h054A, 11);
        check_idle("a5");

        // 07, odd parity (bit 0), two stop bits; inputs scrambled after the transfer.
        tx_if.pdata       = 8'h07;
        tx_if.parity_en   = 1'b1;
        tx_if.parity_type = 1'b1;
        tx_if.stop_two    = 1'b1;
        tx_if.data_valid  = 1'b1;
        tick();
        tx_if.data_valid  = 1'b0;
        tx_if.pdata       = 8'hFF;
        tx_if.parity_en   = 1'b0;
        tx_if.parity_type = 1'b0;
        tx_if.stop_two    = 1'b0;
        check_frame("07", 16'h0C0E, 12);
        check_idle("07");

`ifndef TX_HOLD_REG_EN
        // Valid held high: 3C then C3 back to back, second start right after the stop bit.
        tx_if.pdata      = 8'h3C;
        tx_if.data_valid = 1'b1;
        tick();
        tx_if.pdata = 8'hC3;
        check_frame("3c", 16'h0278, 10);
        check("3c ready at last stop", 32'(tx_if.data_ready), 32'd1);
        tick();
        tx_if.data_valid = 1'b0;
        check_frame("c3", 16'h0386, 10);
        check_idle("c3");
`else
        // 11 starts, 22 offered at edge k+2 lands in the hold entry and follows without a gap.
        tx_if.pdata       = 8'h11;
        tx_if.parity_en   = 1'b0;
        tx_if.stop_two    = 1'b0;
        tx_if.data_valid  = 1'b1;
        tick();
        tx_if.data_valid  = 1'b0;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("11 tx[%0d]", j), 32'(tx_out), 32'(j == 1 || j == 5 || j == 9));
            check($sformatf("11 busy[%0d]", j), 32'(busy), 32'd1);
            check($sformatf("11 done[%0d]", j), 32'(frame_done), (j == 9) ? 32'd1 : 32'd0);
            if (j == 1) begin
                check("hold ready before fill", 32'(tx_if.data_ready), 32'd1);
                tx_if.pdata      = 8'h22;
                tx_if.data_valid = 1'b1;
            end
            if (j >= 2) begin
                tx_if.data_valid = 1'b0;
                check($sformatf("hold ready[%0d]", j), 32'(tx_if.data_ready), 32'd0);
            end
            tick();
        end
        check_frame("22", 16'h0244, 10);
        check_idle("22");
`endif

        // Reset during data bit 3 of 5A abandons the frame.
        tx_if.pdata       = 8'h5A;
        tx_if.parity_en   = 1'b1;
        tx_if.parity_type = 1'b0;
        tx_if.stop_two    = 1'b0;
        tx_if.data_valid  = 1'b1;
        tick();
        tx_if.data_valid  = 1'b0;
        repeat (4) tick();
        check("5a bit3 tx", 32'(tx_out), 32'd1);
        check("5a bit3 busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midreset tx", 32'(tx_out), 32'd1);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(frame_done), 32'd0);
        check("midreset ready", 32'(tx_if.data_ready), 32'd0);
        rst_n = 1'b1;
        check_idle("post reset");

        // 96 after release: odd parity 1, two stop bits.
        tx_if.pdata       = 8'h96;
        tx_if.parity_en   = 1'b1;
        tx_if.parity_type = 1'b1;
        tx_if.stop_two    = 1'b1;
        tx_if.data_valid  = 1'b1;
        tick();
        tx_if.data_valid  = 1'b0;
        check_frame("96", 16'h0F2C, 12);
        check_idle("96");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
